instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 6, sets the instruction-memory word-address width (depth 2^ADDR_W).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  synchronous restart of the write pointer.
REQ-005 in_valid  input  1  encode request is valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 cls  input  4  instruction class: 0 R, 1 LW, 2 SW, 3 BEQ, 4 BLT, 5 ADDI, 6 LUI, 7 LI, 8 J; 9-15 illegal.
REQ-008 rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-009 funct  input  6  R-type function field.
REQ-010 imm  input  16  immediate or branch offset.
REQ-011 target  input  26  jump target field.
REQ-012 imem_we  output  1  instruction-memory write strobe.
REQ-013 imem_waddr  output  ADDR_W  word address.
REQ-014 imem_wdata  output  32  encoded instruction word.
REQ-015 full  output  1  last address has been written.
REQ-016 err  output  1  sticky flag: an illegal class was accepted.
REQ-017 count  output  ADDR_W+1  number of words written since reset or clear.

Function
REQ-018 Opcodes SHALL be: R 000000, LW 100011, SW 101011, BEQ 000100, BLT 000110, ADDI 001000, LUI 001111, LI 011000, J 000010.
REQ-019 R-type encoding SHALL be {op, rs, rt, rd, shamt, funct}.
REQ-020 LW, SW, BEQ, BLT and ADDI SHALL be encoded as {op, rs, rt, imm}.
REQ-021 LUI and LI SHALL be encoded as {op, 5'b0, rt, imm}, ignoring rs.
REQ-022 J SHALL be encoded as {op, target}.
REQ-023 The FSM SHALL have states IDLE, WRITE and FULL.
REQ-024 In IDLE, in_ready SHALL be 1 exactly when clear is 0.
REQ-025 A request is accepted when in_valid and in_ready are both 1.
REQ-026 A legal accept in cycle N SHALL register the word and go to WRITE; imem_we=1 in cycle N+1 with registered waddr/wdata; latency is exactly 1 cycle.
REQ-027 In WRITE, in_ready SHALL be 0 (at most one write every 2 cycles).
REQ-028 WRITE SHALL increment the pointer and count, then return to IDLE, or go to FULL if the written address was 2^ADDR_W-1.
REQ-029 An illegal-class accept SHALL set err, perform no write and stay in IDLE.
REQ-030 FULL SHALL drive full=1 and in_ready=0, and stay in FULL until clear.
REQ-031 clear=1 in any state SHALL, at the next edge, set the pointer and count to 0, set full=0, set state to IDLE and suppress any pending write.
REQ-032 clear SHALL not reset err.
REQ-033 Pointer wrap is impossible: FULL blocks further accepts.
REQ-034 Inputs SHALL be sampled only on the accept cycle; they may change afterwards.
REQ-035 imem_waddr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-036 reset_n=0 SHALL immediately force: state IDLE, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, full=0, err=0, count=0.
REQ-037 in_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-038 Reset asserted mid-WRITE SHALL abort the write (imem_we=0 asynchronously).

Configuration
REQ-039 With INSTR_ENCODER_CHECKSUM_EN defined: add output csum[31:0], reset to 0, set to csum XOR imem_wdata on each imem_we cycle, and zeroed by clear.
REQ-040 Without INSTR_ENCODER_CHECKSUM_EN: no csum port and no checksum logic.

Verification
REQ-041 R accept (rs=8, rt=9, rd=10, shamt=0, funct=0x20) at address 0 -> next cycle imem_we=1, waddr=0, wdata=0x01095020, count=1.
REQ-042 LW (rs=0, rt=2, imm=4), then BEQ (rs=1, rt=2, imm=0xFFFF), then J (target=0x10) -> wdata 0x8C020004, 0x1022FFFF, 0x08000010 at addresses 0, 1, 2.
REQ-043 cls=12 accepted -> err=1, no imem_we, count unchanged; a following legal request is still written.
REQ-044 ADDR_W=2 with 4 back-to-back accepts -> full=1, in_ready=0, a 5th in_valid is ignored; then clear -> count=0, in_ready=1 the next cycle.
REQ-045 reset_n pulsed low during WRITE -> imem_we drops immediately, all outputs return to reset values.
REQ-046 With INSTR_ENCODER_CHECKSUM_EN, after writing 0x01095020 and 0x8C020004 -> csum=0x8D0B5024.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes one instruction per request and writes it to instruction memory.
// Ports: clk, reset_n, clear, in_valid/in_ready, cls/rs/rt/rd/shamt/funct/imm/target in;
//        imem_we/imem_waddr/imem_wdata, full, err, count out.
// Optional: define INSTR_ENCODER_CHECKSUM_EN to add the csum[31:0] output.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cls,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       csum
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              armed;
    logic              accept;
    logic              legal;
    logic [31:0]       word;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        unique case (cls)
            4'd0:    word = {6'b000000, rs, rt, rd, shamt, funct};
            4'd1:    word = {6'b100011, rs, rt, imm};
            4'd2:    word = {6'b101011, rs, rt, imm};
            4'd3:    word = {6'b000100, rs, rt, imm};
            4'd4:    word = {6'b000110, rs, rt, imm};
            4'd5:    word = {6'b001000, rs, rt, imm};
            4'd6:    word = {6'b001111, 5'b0, rt, imm};
            4'd7:    word = {6'b011000, 5'b0, rt, imm};
            4'd8:    word = {6'b000010, target};
            default: legal = 1'b0;
        endcase
    end

    // armed holds in_ready low until the first edge after reset release
    assign in_ready = armed & (state == IDLE) & ~clear;
    assign accept   = in_valid & in_ready;
    // a clear in the write cycle cancels the pending write
    assign imem_we  = (state == WRITE) & ~clear;
    assign full     = (state == FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            armed      <= 1'b0;
            ptr        <= '0;
            count      <= '0;
            err        <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            armed <= 1'b1;
            if (clear) begin
                state <= IDLE;
                ptr   <= '0;
                count <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            if (legal) begin
                                imem_waddr <= ptr;
                                imem_wdata <= word;
                                state      <= WRITE;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        ptr   <= ptr + PTR_ONE;
                        count <= count + CNT_ONE;
                        state <= (ptr == '1) ? FULL : IDLE;
                    end
                    FULL:    state <= FULL;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef INSTR_ENCODER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (imem_we) begin
            csum <= csum ^ imem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder (ADDR_W=2).
// Ports: none; drives clk/reset_n/clear and encode requests.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    cls = '0;
    logic [4:0]    rs = '0;
    logic [4:0]    rt = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    shamt = '0;
    logic [5:0]    funct = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          full;
    logic          err;
    logic [AW:0]   count;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0]   csum;
`endif

    int total = 0;
    int bad = 0;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cls        (cls),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .full       (full),
        .err        (err),
        .count      (count)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        ,
        .csum       (csum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // drive one request for a single cycle, then scramble the fields
    task automatic send(input logic [3:0] c, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d,
                        input logic [4:0] sh, input logic [5:0] f,
                        input logic [15:0] im, input logic [25:0] tg);
        cls = c; rs = s; rt = t; rd = d; shamt = sh;
        funct = f; imm = im; target = tg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cls = 4'd0; rs = 5'h1f; rt = 5'h1f; rd = 5'h1f;
        shamt = 5'h1f; funct = 6'h3f; imm = 16'h5a5a;
        target = 26'h3ffffff;
    endtask

    task automatic wr(input string tag, input logic [3:0] c,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh,
                      input logic [5:0] f, input logic [15:0] im,
                      input logic [25:0] tg, input int a,
                      input logic [31:0] w, input int n);
        send(c, s, t, d, sh, f, im, tg);
        chk({tag, " we"}, 32'(imem_we), 32'd1);
        chk({tag, " addr"}, 32'(imem_waddr), 32'(a));
        chk({tag, " data"}, imem_wdata, w);
        chk({tag, " busy"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, " we off"}, 32'(imem_we), 32'd0);
        chk({tag, " count"}, 32'(count), 32'(n));
        chk({tag, " hold"}, imem_wdata, w);
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        #1;
        chk({tag, " clr ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        chk({tag, " clr count"}, 32'(count), 32'd0);
        chk({tag, " clr full"}, 32'(full), 32'd0);
        chk({tag, " clr ready1"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        chk("rst ready", 32'(in_ready), 32'd0);
        chk("rst we", 32'(imem_we), 32'd0);
        chk("rst addr", 32'(imem_waddr), 32'd0);
        chk("rst data", imem_wdata, 32'd0);
        chk("rst full", 32'(full), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        #10;
        reset_n = 1'b1;
        #1;
        chk("pre edge ready", 32'(in_ready), 32'd0);
        tick();
        chk("post edge ready", 32'(in_ready), 32'd1);

        wr("r", 4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0,
           0, 32'h01095020, 1);
        do_clear("c1");

        wr("lw", 4'd1, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0,
           0, 32'h8C020004, 1);
        wr("beq", 4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0,
           1, 32'h1022FFFF, 2);
        wr("j", 4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10,
           2, 32'h08000010, 3);
        do_clear("c2");

        send(4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 6'h5, 16'h6, 26'h7);
        chk("ill we", 32'(imem_we), 32'd0);
        chk("ill err", 32'(err), 32'd1);
        chk("ill count", 32'(count), 32'd0);
        chk("ill ready", 32'(in_ready), 32'd1);

        wr("addi", 4'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0,
           0, 32'h20641234, 1);
        wr("sw", 4'd2, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0,
           1, 32'hAC430008, 2);
        wr("blt", 4'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0,
           2, 32'h1885FFFC, 3);
        wr("lui", 4'd6, 5'd31, 5'd5, 5'd0, 5'd0, 6'h0, 16'hABCD, 26'h0,
           3, 32'h3C05ABCD, 4);
        chk("full flag", 32'(full), 32'd1);
        chk("full ready", 32'(in_ready), 32'd0);

        cls = 4'd5; rs = 5'd1; rt = 5'd1; imm = 16'h1;
        in_valid = 1'b1;
        tick();
        chk("full ign we", 32'(imem_we), 32'd0);
        tick();
        chk("full ign we2", 32'(imem_we), 32'd0);
        chk("full ign count", 32'(count), 32'd4);
        chk("full stays", 32'(full), 32'd1);
        in_valid = 1'b0;
        do_clear("c3");
        chk("err sticky", 32'(err), 32'd1);

        wr("r2", 4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0,
           0, 32'h01095020, 1);
        wr("lw2", 4'd1, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0,
           1, 32'h8C020004, 2);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("csum", csum, 32'h8D0B5024);
`endif

        send(4'd7, 5'd9, 5'd7, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
        chk("li we", 32'(imem_we), 32'd1);
        chk("li addr", 32'(imem_waddr), 32'd2);
        chk("li data", imem_wdata, 32'h60070001);
        reset_n = 1'b0;
        #1;
        chk("mid rst we", 32'(imem_we), 32'd0);
        chk("mid rst addr", 32'(imem_waddr), 32'd0);
        chk("mid rst data", imem_wdata, 32'd0);
        chk("mid rst count", 32'(count), 32'd0);
        chk("mid rst err", 32'(err), 32'd0);
        chk("mid rst full", 32'(full), 32'd0);
        chk("mid rst ready", 32'(in_ready), 32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("mid rst csum", csum, 32'd0);
`endif
        #2;
        reset_n = 1'b1;
        #1;
        chk("rel ready", 32'(in_ready), 32'd0);
        tick();
        chk("rel ready1", 32'(in_ready), 32'd1);
        chk("rel we", 32'(imem_we), 32'd0);
        chk("rel count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
